// File: rtl/mult18_acc.sv
// Signed multiply-accumulate back end: sums NUM_TERMS 36-bit products into an ACC_LEN-bit result.
// Optional macro MULT18_ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module mult18_acc #(
    parameter int ACC_LEN   = 48,
    parameter int NUM_TERMS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mult18_acc_start,
    input  logic               mult18_acc_in_valid,
    output logic               mult18_acc_in_ready,
    input  logic [35:0]        mult18_acc_in_1,
    output logic               mult18_acc_out_valid,
    input  logic               mult18_acc_out_ready,
    output logic [ACC_LEN-1:0] mult18_acc_out,
    output logic               mult18_acc_busy,
    output logic               mult18_acc_ovf
);
    localparam int CW = $clog2(NUM_TERMS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state;
    logic [ACC_LEN-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               ovf;
    logic               xfer;
    logic               last;
    logic [ACC_LEN:0]   sum;
    logic               sum_ovf;
    logic [ACC_LEN-1:0] acc_nxt;

    assign xfer = mult18_acc_in_valid & mult18_acc_in_ready;
    assign last = (cnt == CW'(NUM_TERMS - 1));

    // One guard bit: the two top bits disagree exactly when the true sum leaves the signed range.
    assign sum     = {acc[ACC_LEN-1], acc}
                   + {{(ACC_LEN - 35){mult18_acc_in_1[35]}}, mult18_acc_in_1};
    assign sum_ovf = sum[ACC_LEN] ^ sum[ACC_LEN-1];

`ifdef MULT18_ACC_SAT_EN
    always_comb begin
        acc_nxt = sum[ACC_LEN-1:0];
        if (sum_ovf)
            acc_nxt = sum[ACC_LEN] ? {1'b1, {(ACC_LEN-1){1'b0}}} : {1'b0, {(ACC_LEN-1){1'b1}}};
    end
`else
    assign acc_nxt = sum[ACC_LEN-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mult18_acc_start) begin
                    state <= ACCUM;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
                ACCUM: if (xfer) begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    ovf <= ovf | sum_ovf;
                    if (last) state <= DONE;
                end
                DONE: if (mult18_acc_out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mult18_acc_in_ready  = (state == ACCUM);
    assign mult18_acc_out_valid = (state == DONE);
    assign mult18_acc_busy      = (state != IDLE);
    assign mult18_acc_out       = acc;
    assign mult18_acc_ovf       = ovf;
endmodule

// File: tb/tb_mult18_acc.sv
// Self-checking bench for mult18_acc: three parameterizations checked against an
// arithmetic reference (true integer sum, then wrap or clamp at each step).
module tb_mult18_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic        in_valid = 1'b0;
    logic [35:0] in_1 = '0;
    logic        out_ready = 1'b0;

    logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, bsy0, bsy1, bsy2, ovf0, ovf1, ovf2;
    logic [47:0] o0, o1;
    logic [35:0] o2;

    always #5 clk = ~clk;

    mult18_acc #(.ACC_LEN(48), .NUM_TERMS(16)) d0 (
        .clk(clk), .rst_n(rst_n), .mult18_acc_start(start[0]), .mult18_acc_in_valid(in_valid),
        .mult18_acc_in_ready(rdy0), .mult18_acc_in_1(in_1), .mult18_acc_out_valid(vld0),
        .mult18_acc_out_ready(out_ready), .mult18_acc_out(o0), .mult18_acc_busy(bsy0),
        .mult18_acc_ovf(ovf0));
    mult18_acc #(.ACC_LEN(48), .NUM_TERMS(4)) d1 (
        .clk(clk), .rst_n(rst_n), .mult18_acc_start(start[1]), .mult18_acc_in_valid(in_valid),
        .mult18_acc_in_ready(rdy1), .mult18_acc_in_1(in_1), .mult18_acc_out_valid(vld1),
        .mult18_acc_out_ready(out_ready), .mult18_acc_out(o1), .mult18_acc_busy(bsy1),
        .mult18_acc_ovf(ovf1));
    mult18_acc #(.ACC_LEN(36), .NUM_TERMS(3)) d2 (
        .clk(clk), .rst_n(rst_n), .mult18_acc_start(start[2]), .mult18_acc_in_valid(in_valid),
        .mult18_acc_in_ready(rdy2), .mult18_acc_in_1(in_1), .mult18_acc_out_valid(vld2),
        .mult18_acc_out_ready(out_ready), .mult18_acc_out(o2), .mult18_acc_busy(bsy2),
        .mult18_acc_ovf(ovf2));

`ifdef MULT18_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int                 sel = 0;
    int                 checks = 0;
    int                 failures = 0;
    logic               rdy, vld, bsy, ovf;
    logic signed [63:0] out_sx;
    logic [35:0]        prod_q[$];

    always_comb begin
        rdy = rdy0; vld = vld0; bsy = bsy0; ovf = ovf0; out_sx = 64'($signed(o0));
        case (sel)
            1: begin rdy = rdy1; vld = vld1; bsy = bsy1; ovf = ovf1; out_sx = 64'($signed(o1)); end
            2: begin rdy = rdy2; vld = vld2; bsy = bsy2; ovf = ovf2; out_sx = 64'($signed(o2)); end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, brought back into range after each term.
    function automatic longint model(input int s, output bit ov);
        int     len = (s == 2) ? 36 : 48;
        longint lo  = -(longint'(1) <<< (len - 1));
        longint hi  = (longint'(1) <<< (len - 1)) - 1;
        longint a   = 0;
        ov = 1'b0;
        foreach (prod_q[i]) begin
            a = a + longint'($signed(prod_q[i]));
            if (a > hi) begin ov = 1'b1; a = SAT ? hi : a - (longint'(1) <<< len); end
            if (a < lo) begin ov = 1'b1; a = SAT ? lo : a + (longint'(1) <<< len); end
        end
        return a;
    endfunction

    task automatic run(input int s, input bit bubble, input int stall, input int start_at,
                       input bit done_start);
        longint exp_sum;
        bit     exp_ovf;
        int     idx = 0;
        int     cyc = 0;
        logic   xfer;
        sel = s;
        exp_sum = model(s, exp_ovf);
        start[s] = 1'b1;
        step();
        start = '0;
        chk("accum_entry", {bsy, rdy, vld}, 3'b110);
        while (idx < prod_q.size()) begin
            if (cyc > 300) begin
                checks++; failures++;
                $error("FAIL feed_timeout observed=%0d transfers expected=%0d", idx, prod_q.size());
                break;
            end
            in_valid = bubble ? (cyc % 3 == 0) : 1'b1;
            in_1     = prod_q[idx];
            start[s] = (idx == start_at);
            chk("no_early_valid", vld, 0);
            xfer = in_valid & rdy;
            step();
            cyc++;
            if (xfer) idx++;
        end
        in_valid = 1'b0;
        start    = '0;
        chk("done_valid", {vld, rdy, bsy}, 3'b101);
        chk("done_sum", out_sx, exp_sum);
        chk("done_ovf", ovf, exp_ovf);
        out_ready = 1'b0;
        repeat (stall) begin
            step();
            chk("stall_valid", vld, 1);
            chk("stall_sum", out_sx, exp_sum);
        end
        out_ready = 1'b1;
        start[s]  = done_start;
        step();
        out_ready = 1'b0;
        start     = '0;
        chk("idle_after_hs", {vld, bsy, rdy}, 3'b000);
        chk("sum_kept", out_sx, exp_sum);
        if (done_start) begin
            step();
            chk("start_in_done_ignored", {bsy, rdy}, 2'b00);
        end
    endtask

    initial begin
        logic [63:0] r;
        int          s, n;
        // Reset state
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            chk("reset_state", {rdy, vld, bsy, ovf}, 4'b0000);
            chk("reset_out", out_sx, 0);
        end
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of an accumulation
        sel = 0;
        start[0] = 1'b1; step(); start = '0;
        in_valid = 1'b1; in_1 = 36'd100;
        repeat (5) step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {rdy, vld, bsy, ovf}, 4'b0000);
        chk("midrst_out", out_sx, 0);
        step();
        rst_n = 1'b1;
        step();
        prod_q = {};
        repeat (16) prod_q.push_back(36'd1);
        run(0, 1'b0, 0, -1, 1'b0);
        chk("after_reset_16", out_sx, 16);

        // Basic dot product
        prod_q = {36'd3, -36'sd7, 36'd1000, -36'sd1};
        run(1, 1'b0, 0, -1, 1'b0);
        chk("dot_995", out_sx, 995);

        // Bubbles and backpressure on max positive products
        prod_q = {};
        repeat (16) prod_q.push_back(36'h7FFFFFFFF);
        run(0, 1'b1, 5, -1, 1'b0);
        chk("max16", out_sx, 16 * ((longint'(1) <<< 35) - 1));

        // Start pulses during ACCUM and together with the DONE handshake
        prod_q = {};
        repeat (16) begin r = {$urandom(), $urandom()}; prod_q.push_back(r[35:0]); end
        run(0, 1'b0, 2, 2, 1'b1);

        // Overflow at ACC_LEN=36
        prod_q = {36'h7FFFFFFFF, 36'd1, 36'd0};
        run(2, 1'b0, 0, -1, 1'b0);
        chk("pos_ovf_out", out_sx, SAT ? (longint'(1) <<< 35) - 1 : -(longint'(1) <<< 35));
        prod_q = {36'h800000000, -36'sd1, 36'd5};
        run(2, 1'b0, 1, -1, 1'b0);
        chk("neg_ovf_out", out_sx, SAT ? -(longint'(1) <<< 35) + 5 : -(longint'(1) <<< 35) + 4);

        // Randomized runs across all three configurations
        for (int t = 0; t < 12; t++) begin
            s = int'($urandom_range(2, 0));
            n = (s == 0) ? 16 : (s == 1) ? 4 : 3;
            prod_q = {};
            for (int i = 0; i < n; i++) begin
                r = {$urandom(), $urandom()};
                if ($urandom_range(3, 0) == 0) r = r[0] ? 64'h800000000 : 64'h7FFFFFFFF;
                prod_q.push_back(r[35:0]);
            end
            run(s, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), -1, 1'b0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
